// File: rtl/systolic_feeder.sv
// Loads N A-words then N B-words, streams them diagonally skewed into the OR-AND array, drains, reads out.
// Outputs registered (+1 cycle); last B transfer to done = 4N+1 cycles; in_ready only while loading, holds source otherwise.
module systolic_feeder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [N-1:0] sa_in1,
  output logic [N-1:0] sa_in2,
  output logic         sa_clear,
  output logic         sa_readout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(2 * N);
  localparam int DW = CW + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_READ   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [N-1:0]  a_buf [N];
  logic [N-1:0]  b_buf [N];
  logic [N-1:0]  skew1, skew2, in1_d, in2_d;
  logic          clear_d, readout_d, busy_d, done_d, wr_a, wr_b, xfer;

  assign in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign xfer     = in_valid && in_ready;

  // Lane j at step t carries bit j of word t-j; out-of-range diagonals feed zero.
  always_comb begin
    logic signed [CW:0] diff;
    diff  = '0;
    skew1 = '0;
    skew2 = '0;
    for (int j = 0; j < N; j++) begin
      diff = $signed({1'b0, cnt}) - $signed(DW'(j));
      if (!diff[CW] && (diff < $signed(DW'(N)))) begin
        skew1[j] = a_buf[diff[IW-1:0]][j];
        skew2[j] = b_buf[diff[IW-1:0]][j];
      end
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    in1_d     = '0;
    in2_d     = '0;
    clear_d   = 1'b0;
    readout_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    case (state)
      S_LOAD_A: if (xfer) begin
        wr_a = 1'b1;
        if (cnt == CW'(N - 1)) begin
          state_d = S_LOAD_B;
          cnt_d   = '0;
        end else cnt_d = cnt + CW'(1);
      end
      S_LOAD_B: if (xfer) begin
        wr_b = 1'b1;
        if (cnt == CW'(N - 1)) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else cnt_d = cnt + CW'(1);
      end
      S_CLEAR: begin
        clear_d = 1'b1;
        busy_d  = 1'b1;
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      S_STREAM: begin
        busy_d = 1'b1;
        in1_d  = skew1;
        in2_d  = skew2;
        if (cnt == CW'(2 * N - 2)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else cnt_d = cnt + CW'(1);
      end
      S_DRAIN: begin
        busy_d = 1'b1;
        if (cnt == CW'(N - 1)) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else cnt_d = cnt + CW'(1);
      end
      S_READ: begin
        busy_d    = 1'b1;
        readout_d = 1'b1;
        if (cnt == CW'(N - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else cnt_d = cnt + CW'(1);
      end
      S_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_LOAD_A;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_LOAD_A;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides everything, including a pending done; the array gets a clear pulse.
    if (abort) begin
      state_d   = S_LOAD_A;
      cnt_d     = '0;
      in1_d     = '0;
      in2_d     = '0;
      clear_d   = 1'b1;
      readout_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      wr_a      = 1'b0;
      wr_b      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD_A;
      cnt        <= '0;
      sa_in1     <= '0;
      sa_in2     <= '0;
      sa_clear   <= 1'b0;
      sa_readout <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int k = 0; k < N; k++) begin
        a_buf[k] <= '0;
        b_buf[k] <= '0;
      end
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sa_in1     <= in1_d;
      sa_in2     <= in2_d;
      sa_clear   <= clear_d;
      sa_readout <= readout_d;
      busy       <= busy_d;
      done       <= done_d;
      if (wr_a) a_buf[cnt[IW-1:0]] <= in_data;
      if (wr_b) b_buf[cnt[IW-1:0]] <= in_data;
    end
  end

endmodule
